// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one WIDTH x WIDTH unsigned multiplier between two requesters
//   (0: ALU multiply path, 1: mux-by-multiply select logic). Round-robin
//   arbitration with valid/ready on the input side. The result is held
//   with its own valid/ready and a requester tag until it is consumed.
//
//   Optional build macro MULT_ARB_PIPE2_EN: adds a MUL2 state and a second
//   product register between MUL and HOLD. Latency goes from 2 to 3 cycles;
//   handshake, arbitration and reset behaviour are unchanged.
//
// Ports
//   clk, n_reset                   clock, async active-low reset
//   req0_valid/a/b, req0_ready     requester 0 operands and handshake
//   req1_valid/a/b, req1_ready     requester 1 operands and handshake
//   res_valid, res_id, res_data    held product, owner tag
//   res_ready                      consumer takes the result
//   busy                           high whenever the FSM is not IDLE
module mult_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic               req0_valid,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               req1_ready,
   output logic               res_valid,
   output logic               res_id,
   output logic [2*WIDTH-1:0] res_data,
   input  logic               res_ready,
   output logic               busy
);

`ifdef MULT_ARB_PIPE2_EN
   typedef enum logic [1:0] {IDLE, MUL, MUL2, HOLD} state_t;
   logic [2*WIDTH-1:0] prod_q;
`else
   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
`endif

   state_t             state, state_nxt;
   logic               last_grant;
   logic               tag;
   logic [WIDTH-1:0]   op_a, op_b;
   logic               gnt0, gnt1;
   logic [2*WIDTH-1:0] prod;

   // Widen both operands first so the product keeps all 2*WIDTH bits.
   assign prod = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         IDLE: begin
            // On contention the requester that did not win last time goes.
            if (req0_valid && (!req1_valid || last_grant)) gnt0 = 1'b1;
            else if (req1_valid)                           gnt1 = 1'b1;
            if (gnt0 || gnt1) state_nxt = MUL;
         end
`ifdef MULT_ARB_PIPE2_EN
         MUL:     state_nxt = MUL2;
         MUL2:    state_nxt = HOLD;
`else
         MUL:     state_nxt = HOLD;
`endif
         HOLD:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Readies are gated by reset so nothing is offered while reset is held.
   assign req0_ready = n_reset & gnt0;
   assign req1_ready = n_reset & gnt1;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         last_grant <= 1'b1;   // first contended grant after reset goes to 0
         tag        <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         res_valid  <= 1'b0;
         res_id     <= 1'b0;
         res_data   <= '0;
`ifdef MULT_ARB_PIPE2_EN
         prod_q     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  op_a       <= gnt1 ? req1_a : req0_a;
                  op_b       <= gnt1 ? req1_b : req0_b;
                  tag        <= gnt1;
                  last_grant <= gnt1;
               end
            end
`ifdef MULT_ARB_PIPE2_EN
            MUL:  prod_q <= prod;
            MUL2: begin
               res_data  <= prod_q;
               res_id    <= tag;
               res_valid <= 1'b1;
            end
`else
            MUL: begin
               res_data  <= prod;
               res_id    <= tag;
               res_valid <= 1'b1;
            end
`endif
            HOLD: if (res_ready) res_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
   localparam int W = 8;
`ifdef MULT_ARB_PIPE2_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic           clk = 1'b0;
   logic           n_reset = 1'b0;
   logic           req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic           req0_ready, req1_ready;
   logic           res_valid, res_id, busy;
   logic [2*W-1:0] res_data;
   logic           res_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mult_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .n_reset(n_reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      tick();
      n_reset = 1'b1;
   endtask

   task automatic test_reset();
      n_reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      tick(); tick(); #1;
      total++;
      if ({res_valid, res_id, res_data, busy, req0_ready, req1_ready} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got vld=%b id=%b data=%h busy=%b rdy=%b%b exp all 0",
                  res_valid, res_id, res_data, busy, req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
      n_reset = 1'b1;
      tick();
      total++;
      if ({busy, req0_ready, req1_ready, res_valid} !== 4'b0) begin
         bad++;
         $display("FAIL reset_release_idle got busy=%b rdy=%b%b vld=%b exp 0",
                  busy, req0_ready, req1_ready, res_valid);
      end
   endtask

   task automatic test_basic();
      req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd5; #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++; $display("FAIL basic_grant got rdy=%b%b exp 10", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; #1;
      for (int k = 1; k < LAT; k++) begin
         total++;
         if ({req0_ready, busy, res_valid} !== 3'b010) begin
            bad++;
            $display("FAIL basic_latency k=%0d got rdy0=%b busy=%b vld=%b exp 0 1 0",
                     k, req0_ready, busy, res_valid);
         end
         tick();
      end
      total++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 16'd15}) begin
         bad++;
         $display("FAIL basic_result got vld=%b id=%b data=%0d exp 1 0 15", res_valid, res_id, res_data);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total++;
      if ({busy, res_valid} !== 2'b00) begin
         bad++; $display("FAIL basic_consume got busy=%b vld=%b exp 0 0", busy, res_valid);
      end
   endtask

   task automatic test_alternate();
      int n = 0;
      int last_cyc = -1;
      logic [2*W-1:0] exp_d;
      do_reset();
      req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd7;
      req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd4;
      res_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
         #1;
         if (res_valid === 1'b1) begin
            exp_d = n[0] ? 16'd16 : 16'd14;
            total++;
            if ({res_id, res_data} !== {n[0], exp_d}) begin
               bad++;
               $display("FAIL alt_result n=%0d got id=%b data=%0d exp id=%b data=%0d",
                        n, res_id, res_data, n[0], exp_d);
            end
            if (n > 0) begin
               total++;
               if (cyc - last_cyc != LAT + 1) begin
                  bad++;
                  $display("FAIL alt_spacing got=%0d exp=%0d", cyc - last_cyc, LAT + 1);
               end
            end
            last_cyc = cyc;
            n++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
      total++;
      if (n != 6) begin
         bad++; $display("FAIL alt_count got=%0d exp=6", n);
      end
      tick();
   endtask

   task automatic test_max();
      req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF; #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         bad++; $display("FAIL max_grant got rdy=%b%b exp 01", req0_ready, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      for (int i = 0; i < 10 && res_valid !== 1'b1; i++) tick();
      total++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 16'hFE01}) begin
         bad++;
         $display("FAIL max_result got vld=%b id=%b data=%h exp 1 1 fe01", res_valid, res_id, res_data);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd11; #1;
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 10 && res_valid !== 1'b1; i++) tick();
      req0_valid = 1'b1; req0_a = 8'd6; req0_b = 8'd6;
      req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd5;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if ({res_valid, busy, req0_ready, req1_ready, res_id, res_data} !==
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd99}) begin
            bad++;
            $display("FAIL hold_stable i=%0d got vld=%b busy=%b rdy=%b%b id=%b data=%0d exp 1 1 00 0 99",
                     i, res_valid, busy, req0_ready, req1_ready, res_id, res_data);
         end
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0; #1;
      total++;
      if ({busy, req0_ready, req1_ready} !== 3'b001) begin
         bad++;
         $display("FAIL hold_release_grant got busy=%b rdy=%b%b exp 0 01", busy, req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 10 && res_valid !== 1'b1; i++) tick();
      total++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 16'd25}) begin
         bad++;
         $display("FAIL hold_next_result got vld=%b id=%b data=%0d exp 1 1 25", res_valid, res_id, res_data);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd3; #1;
      tick();
      req0_valid = 1'b0;
      #2; n_reset = 1'b0; #1;
      total++;
      if ({res_valid, busy} !== 2'b00) begin
         bad++; $display("FAIL rst_mul got vld=%b busy=%b exp 0 0", res_valid, busy);
      end
      tick();
      n_reset = 1'b1;
      req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd6;
      req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2; #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++; $display("FAIL rst_first_grant got rdy=%b%b exp 10", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 10 && res_valid !== 1'b1; i++) tick();
      total++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 16'd42}) begin
         bad++;
         $display("FAIL rst_result got vld=%b id=%b data=%0d exp 1 0 42", res_valid, res_id, res_data);
      end
      #2; n_reset = 1'b0; #1;
      total++;
      if ({res_valid, busy} !== 2'b00) begin
         bad++; $display("FAIL rst_hold got vld=%b busy=%b exp 0 0", res_valid, busy);
      end
      tick();
      n_reset = 1'b1;
   endtask

   task automatic test_random();
      bit pend = 1'b0, last = 1'b1, eid = 1'b0;
      bit g0, g1, evld;
      int age = 0, nres = 0;
      logic [2*W-1:0] edata = '0;
      bit v0 = 1'b0, v1 = 1'b0;
      logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); end
         if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom); end
         req0_valid = v0; req0_a = a0; req0_b = b0;
         req1_valid = v1; req1_a = a1; req1_b = b1;
         res_ready = ($urandom_range(0, 3) != 0);
         #1;
         // Round-robin rule: single requester wins; on contention the one
         // that did not win last time.
         g0 = 1'b0; g1 = 1'b0;
         if (!pend) begin
            if (v0 && v1) begin
               if (last) g0 = 1'b1; else g1 = 1'b1;
            end else if (v0) g0 = 1'b1;
            else if (v1) g1 = 1'b1;
         end
         evld = pend && (age >= LAT);
         total++;
         if ({req0_ready, req1_ready, busy, res_valid} !== {g0, g1, pend, evld}) begin
            bad++;
            $display("FAIL rand_ctrl cyc=%0d got rdy=%b%b busy=%b vld=%b exp rdy=%b%b busy=%b vld=%b",
                     cyc, req0_ready, req1_ready, busy, res_valid, g0, g1, pend, evld);
         end
         if (evld) begin
            total++;
            if ({res_id, res_data} !== {eid, edata}) begin
               bad++;
               $display("FAIL rand_result cyc=%0d got id=%b data=%h exp id=%b data=%h",
                        cyc, res_id, res_data, eid, edata);
            end
         end
         tick();
         if (g0 || g1) begin
            pend  = 1'b1;
            age   = 1;
            eid   = g1;
            last  = g1;
            edata = g1 ? (2*W)'(a1) * (2*W)'(b1) : (2*W)'(a0) * (2*W)'(b0);
            if (g0) v0 = 1'b0; else v1 = 1'b0;
         end else if (pend) begin
            if (evld && res_ready) begin pend = 1'b0; nres++; end
            else age++;
         end
         // A requester may give up before being served.
         if (v0 && $urandom_range(0, 15) == 0) v0 = 1'b0;
         if (v1 && $urandom_range(0, 15) == 0) v1 = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
      total++;
      if (nres < 20) begin
         bad++; $display("FAIL rand_throughput got=%0d exp>=20", nres);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alternate();
      test_max();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one WIDTH x WIDTH unsigned multiplier between two requesters:
  - requester 0: ALU multiply path;
  - requester 1: mux-by-multiply select logic.
- Round-robin arbitration; valid/ready handshake on the input side; held result with its own valid/ready and a requester tag.
- Sits between the decode/ALU stage and the single shared hardware multiplier, so multiplier cost is paid once.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  clock, all state on rising edge
n_reset  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has operands
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_ready  output  1  requester 0 accepted this cycle
req1_valid  input  1  requester 1 has operands
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_ready  output  1  requester 1 accepted this cycle
res_valid  output  1  result held on res_data
res_id  output  1  requester that owns the result (0/1)
res_data  output  2*WIDTH  unsigned product a*b
res_ready  input  1  consumer takes the result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous and active-low:
  - n_reset low forces state=IDLE, last_grant=1, res_valid=0, res_id=0, res_data=0, busy=0, both req*_ready=0;
  - operand registers are cleared to 0.
- The FSM has three states:
  - IDLE: arbitrate.
  - MUL: registered operands drive the multiplier.
  - HOLD: result presented until consumed.
- Grant rules, in IDLE only:
  - only one valid: grant it;
  - both valid: grant the requester != last_grant;
  - neither valid: no grant.
  - req*_ready is combinational, high for the granted requester only, and low in every other state.
  - A transfer occurs on the rising edge where valid && ready. At that edge: operands latch into op_a/op_b, the tag latches, last_grant is updated, and state goes to MUL.
- MUL → HOLD on the next edge, unconditionally:
  - res_data <= op_a*op_b, full 2*WIDTH, unsigned, no truncation;
  - res_id <= tag; res_valid <= 1.
- Latency: res_valid is high 2 cycles after the accept edge.
- HOLD:
  - res_valid, res_data and res_id stay stable while res_ready=0, with no timeout.
  - On the edge with res_ready=1: res_valid <= 0, state → IDLE.
  - The next accept can occur in the following cycle. Peak throughput is 1 result per 3 cycles.
- Requesters keep valid and operands stable until ready. A valid that is dropped before grant is simply not served.
- A requester denied due to round-robin waits. With both requesters continuously valid, grants alternate strictly: 0,1,0,1,...
- res_data is undefined-free: it holds the last product after consumption, but only res_valid qualifies it.
- Reset mid-operation (MUL or HOLD): any in-flight result is discarded and res_valid drops immediately. After release, the first simultaneous request goes to requester 0.
- res_ready high outside HOLD is ignored.

Optional Feature:
MULT_ARB_PIPE2_EN:
- Defined:
  - adds state MUL2 and a second product register after MUL, for timing on slow fabric;
  - path is MUL → MUL2 → HOLD;
  - latency 3 cycles from the accept edge to res_valid;
  - all handshake, arbitration and reset rules are unchanged.
- Undefined: the 2-cycle latency above; the MUL2 state and its register are absent.

Test Plan:
- Reset, then release; req0_valid=1, a=3, b=5 → req0_ready=1 for one cycle. Two cycles later res_valid=1, res_id=0, res_data=15. With res_ready=1, the next cycle returns to IDLE with busy=0.
- req0 and req1 valid every cycle with (a,b) = (2,7) and (4,4), res_ready tied 1 → result ids alternate 0,1,0,1 with res_data 14,16,14,16. One result every 3 cycles.
- req1 a=8'hFF, b=8'hFF → res_data=16'hFE01; no truncation.
- Backpressure: result held in HOLD with res_ready=0 for 10 cycles → res_valid and res_data stable, req0_ready and req1_ready stay 0 despite valid requests, busy=1. res_ready=1 releases the result and a new grant occurs the following cycle.
- Assert n_reset low during MUL, without waiting for a clock edge → res_valid=0 and busy=0 immediately. After release with both valid, requester 0 is granted first.
- With MULT_ARB_PIPE2_EN defined, repeat the first scenario → res_valid at 3 cycles after accept, res_data=15.
